// File: rtl/core_dmem_ctrl.sv
// rtl/core_dmem_ctrl.sv - LSU data-memory slave with byte-lane writes and pipelined extended reads
// Optional DMEM_ERR_EN adds dmem_err and rejects misaligned/illegal accesses instead of force-aligning.
module core_dmem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dmem_wen,
  input  logic        dmem_ren,
  input  logic [2:0]  dmem_rwtyp,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_wack,
  output logic        dmem_rvld,
`ifdef DMEM_ERR_EN
  output logic        dmem_err,
`endif
  output logic [31:0] dmem_rdata
);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              is_b, is_h, illegal, wr_block, wr_ok, rd_go;
  logic [1:0]        lane;
  logic [4:0]        sh;
  logic [3:0]        be;
  logic [31:0]       wd, lane_w, rd_ext;
  logic              unused_addr_hi;

  assign idx            = dmem_addr[ADDR_W+1:2];
  assign unused_addr_hi = |dmem_addr[31:ADDR_W+2];
  assign is_b           = (dmem_rwtyp[1:0] == 2'b00);
  assign is_h           = (dmem_rwtyp[1:0] == 2'b01);
  assign illegal        = (dmem_rwtyp == 3'b011) || (dmem_rwtyp[2:1] == 2'b11);

  // Halfword/word lanes ignore the low address bits, which is the force-align behaviour.
  assign lane = is_b ? dmem_addr[1:0] : (is_h ? {dmem_addr[1], 1'b0} : 2'b00);
  assign sh   = {lane, 3'b000};
  assign be   = is_b ? (4'b0001 << lane) : (is_h ? (4'b0011 << lane) : 4'b1111);
  assign wd   = dmem_wdata << sh;

`ifdef DMEM_ERR_EN
  logic misalign, bad;
  assign misalign = (is_h & dmem_addr[0]) | (~is_b & ~is_h & (|dmem_addr[1:0]));
  assign bad      = misalign | illegal;
  assign wr_block = bad;
`else
  assign wr_block = illegal;
`endif

  assign wr_ok  = dmem_wen & ~wr_block;
  assign rd_go  = dmem_ren & ~dmem_wen;
  assign lane_w = mem[idx] >> sh;

  always_comb begin
    rd_ext = lane_w;
    if (is_b)
      rd_ext = dmem_rwtyp[2] ? {24'd0, lane_w[7:0]} : {{24{lane_w[7]}}, lane_w[7:0]};
    else if (is_h)
      rd_ext = dmem_rwtyp[2] ? {16'd0, lane_w[15:0]} : {{16{lane_w[15]}}, lane_w[15:0]};
`ifdef DMEM_ERR_EN
    if (bad)
      rd_ext = 32'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  logic [RD_LAT-1:0] vld_q;
  logic [31:0]       dat_q [RD_LAT];

  // Data stages only load on a valid beat so the last stage holds the previous result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dmem_wack <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < RD_LAT; i++)
        dat_q[i] <= 32'd0;
    end else begin
      dmem_wack <= dmem_wen;
      vld_q[0]  <= rd_go;
      if (rd_go)
        dat_q[0] <= rd_ext;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1])
          dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign dmem_rvld  = vld_q[RD_LAT-1];
  assign dmem_rdata = dat_q[RD_LAT-1];

`ifdef DMEM_ERR_EN
  logic              werr_q;
  logic [RD_LAT-1:0] rerr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      werr_q <= 1'b0;
      rerr_q <= '0;
    end else begin
      werr_q    <= dmem_wen & bad;
      rerr_q[0] <= rd_go & bad;
      for (int i = 1; i < RD_LAT; i++)
        rerr_q[i] <= rerr_q[i-1];
    end
  end

  assign dmem_err = werr_q | rerr_q[RD_LAT-1];
`endif

endmodule

// File: tb/tb_core_dmem_ctrl.sv
// tb/tb_core_dmem_ctrl.sv - randomized + directed bench for core_dmem_ctrl against a byte-array model
module tb_core_dmem_ctrl;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dmem_wen = 1'b0, dmem_ren = 1'b0;
  logic [2:0]  dmem_rwtyp = 3'd0;
  logic [31:0] dmem_addr = 32'd0, dmem_wdata = 32'd0;
  logic        dmem_wack, dmem_rvld;
  logic [31:0] dmem_rdata;
`ifdef DMEM_ERR_EN
  logic        dmem_err;
`endif

  core_dmem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
    .dmem_rwtyp(dmem_rwtyp), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wack(dmem_wack), .dmem_rvld(dmem_rvld),
`ifdef DMEM_ERR_EN
    .dmem_err(dmem_err),
`endif
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit prev_rst = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_rst <= !rstn;
  end

  logic [7:0]  mb [4*DEPTH];
  logic [31:0] exp_rd [int];
  bit          exp_re [int];
  bit          exp_wk [int];
  bit          exp_we [int];
  logic [31:0] last_rd = 32'd0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
  endtask

  function automatic int sz(logic [2:0] t);
    if (t == 3'd0 || t == 3'd4) return 1;
    if (t == 3'd1 || t == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit legal(logic [2:0] t);
    return t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5;
  endfunction

  function automatic bit bad_acc(logic [2:0] t, logic [31:0] a);
`ifdef DMEM_ERR_EN
    return !legal(t) || (int'(a[1:0]) % sz(t) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int byte_at(logic [2:0] t, logic [31:0] a);
    int s = sz(t);
    return int'(a[ADDR_W+1:2]) * 4 + (int'(a[1:0]) / s) * s;
  endfunction

  // {err, value} the LSU must see for a load
  function automatic logic [32:0] model_read(logic [2:0] t, logic [31:0] a);
    logic [31:0] v = 32'd0;
    int b = byte_at(t, a);
    if (bad_acc(t, a)) return {1'b1, 32'd0};
    for (int i = 0; i < sz(t); i++) v = v | (32'(mb[b+i]) << (8*i));
    case (t)
      3'd0: if (v[7])  v = v - 32'h100;
      3'd1: if (v[15]) v = v - 32'h10000;
      default: ;
    endcase
    return {1'b0, v};
  endfunction

  task automatic issue(bit w, bit r, logic [2:0] t, logic [31:0] a, logic [31:0] d);
    logic [32:0] res;
    @(posedge clk); #1;
    dmem_wen = w; dmem_ren = r; dmem_rwtyp = t; dmem_addr = a; dmem_wdata = d;
    if (w) begin
      exp_wk[cyc+1] = 1'b1;
      exp_we[cyc+1] = bad_acc(t, a) || !legal(t);
      if (legal(t) && !bad_acc(t, a))
        for (int i = 0; i < sz(t); i++) mb[byte_at(t, a)+i] = d[8*i +: 8];
    end else if (r) begin
      res = model_read(t, a);
      exp_rd[cyc+RD_LAT] = res[31:0];
      exp_re[cyc+RD_LAT] = res[32];
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dmem_wen = 1'b0; dmem_ren = 1'b0;
    end
  endtask

  task automatic rd_pin(string nm, logic [2:0] t, logic [31:0] a, logic [32:0] lit);
    chk(nm, {31'd0, model_read(t, a) === lit}, 32'd1);
    issue(1'b0, 1'b1, t, a, 32'd0);
  endtask

  task automatic do_reset(int n);
    int ks[$];
    @(posedge clk); #1;
    rstn = 1'b0; dmem_wen = 1'b0; dmem_ren = 1'b0;
    foreach (exp_rd[k]) if (k > cyc) ks.push_back(k);
    foreach (exp_wk[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) begin
      exp_rd.delete(ks[i]); exp_re.delete(ks[i]);
      exp_wk.delete(ks[i]); exp_we.delete(ks[i]);
    end
    repeat (n) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    bit          e_rv, e_wk, e_err;
    logic [31:0] e_dat;
    if (cyc > 0) begin
      if (prev_rst) begin
        chk("rst_rvld", {31'd0, dmem_rvld}, 32'd0);
        chk("rst_wack", {31'd0, dmem_wack}, 32'd0);
        chk("rst_rdata", dmem_rdata, 32'd0);
`ifdef DMEM_ERR_EN
        chk("rst_err", {31'd0, dmem_err}, 32'd0);
`endif
        last_rd = 32'd0;
      end else begin
        e_rv  = exp_rd.exists(cyc);
        e_dat = e_rv ? exp_rd[cyc] : last_rd;
        e_wk  = exp_wk.exists(cyc);
        e_err = (e_rv && exp_re[cyc]) || (e_wk && exp_we[cyc]);
        chk("rvld", {31'd0, dmem_rvld}, {31'd0, e_rv});
        chk("rdata", dmem_rdata, e_dat);
        chk("wack", {31'd0, dmem_wack}, {31'd0, e_wk});
`ifdef DMEM_ERR_EN
        chk("err", {31'd0, dmem_err}, {31'd0, e_err});
`endif
        last_rd = e_dat;
        exp_rd.delete(cyc); exp_re.delete(cyc);
        exp_wk.delete(cyc); exp_we.delete(cyc);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int op;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 3'd2, 32'(i*4), $urandom());

    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'hDEADBEEF);
    idle(1);
    rd_pin("pin_lw100", 3'd2, 32'h100, {1'b0, 32'hDEADBEEF});
    issue(1'b1, 1'b0, 3'd0, 32'h103, 32'h7F);
    rd_pin("pin_lb103", 3'd0, 32'h103, {1'b0, 32'h0000007F});
    issue(1'b1, 1'b0, 3'd0, 32'h102, 32'h80);
    rd_pin("pin_lb102", 3'd0, 32'h102, {1'b0, 32'hFFFFFF80});
    rd_pin("pin_lbu102", 3'd4, 32'h102, {1'b0, 32'h00000080});
    issue(1'b1, 1'b0, 3'd2, 32'h104, 32'h12345678);
    issue(1'b1, 1'b0, 3'd1, 32'h106, 32'h8001);
    rd_pin("pin_lh106", 3'd1, 32'h106, {1'b0, 32'hFFFF8001});
    rd_pin("pin_lhu106", 3'd5, 32'h106, {1'b0, 32'h00008001});
    rd_pin("pin_lw104", 3'd2, 32'h104, {1'b0, 32'h80015678});

    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 3'd2, 32'(i*4), 32'(i+1));
    for (int i = 0; i < 4; i++) rd_pin("pin_b2b", 3'd2, 32'(i*4), {1'b0, 32'(i+1)});
    idle(RD_LAT + 2);

    issue(1'b0, 1'b1, 3'd2, 32'h0, 32'd0);
    do_reset(2);
    idle(RD_LAT + 2);

`ifdef DMEM_ERR_EN
    rd_pin("pin_lw102", 3'd2, 32'h102, {1'b1, 32'h0});
`else
    rd_pin("pin_lw102", 3'd2, 32'h102, {1'b0, 32'h7F80BEEF});
`endif
    issue(1'b1, 1'b1, 3'd2, 32'h8, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 3'd3, 32'h8, 32'h0);
    rd_pin("pin_both", 3'd2, 32'h8, {1'b0, 32'hCAFEF00D});

    for (int i = 0; i < 2500; i++) begin
      op = $urandom_range(0, 9);
      a  = $urandom() & 32'hFFFFF03F;
      d  = $urandom();
      if (op < 4)       issue(1'b1, 1'b0, 3'($urandom_range(0, 7)), a, d);
      else if (op < 8)  issue(1'b0, 1'b1, 3'($urandom_range(0, 7)), a, d);
      else if (op == 8) issue(1'b1, 1'b1, 3'($urandom_range(0, 7)), a, d);
      else              idle(1);
    end
    idle(RD_LAT + 3);
    chk("drained", 32'(exp_rd.num() + exp_wk.num()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/core_dmem_ctrl.md
Name: core_dmem_ctrl

Overview:
- Data-memory slave directly downstream of the LSU bus port.
- Accepts single-cycle read/write strobes with a RISC-V func3 access type and a byte address. Performs byte-lane writes into an internal word array.
- Returns reads after a fixed pipelined latency, already lane-aligned and sign/zero-extended, so the LSU can forward them straight to writeback.
- Write completion is acknowledged with a one-cycle pulse.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W 32-bit words.
- RD_LAT, 2, read latency in cycles from strobe to dmem_rvld; legal range 1..8.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset.
- dmem_wen  input  1  write strobe; one request per asserted cycle.
- dmem_ren  input  1  read strobe; one request per asserted cycle.
- dmem_rwtyp  input  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_addr  input  32  byte address.
- dmem_wdata  input  32  store data, LSB-justified.
- dmem_wack  output  1  write acknowledge pulse.
- dmem_rvld  output  1  read data valid pulse.
- dmem_rdata  output  32  extended load result.
- dmem_err  output  1  misaligned or illegal access flag (only with DMEM_ERR_EN).

Behaviour:
- Reset (rstn=0 at posedge): dmem_wack=0, dmem_rvld=0, dmem_rdata=0, dmem_err=0. All read-pipeline valid bits are cleared, so in-flight reads are dropped and never produce dmem_rvld. Array contents are not reset.
- Word index = dmem_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size. Byte lane = dmem_addr[1:0].
- Write, cycle N:
  - B: lane k = addr[1:0] gets wdata[7:0].
  - H: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - W: all four lanes get wdata.
  - Array is updated at the posedge ending cycle N.
  - dmem_wack=1 in cycle N+1 only.
- Read, cycle N:
  - Array word is sampled at the posedge ending cycle N, so it reflects any write completed in an earlier cycle.
  - The selected lane(s) are shifted to bit 0. B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - Result travels through an RD_LAT-stage valid/data shift pipeline. dmem_rvld=1 and dmem_rdata are valid in cycle N+RD_LAT for exactly one cycle.
  - dmem_rdata holds its last value when dmem_rvld=0.
- Back-to-back reads are accepted one per cycle with no bubbles; responses return in request order.
- Read and write requests may interleave freely. wack and rvld may assert in the same cycle.
- dmem_wen and dmem_ren both high in one cycle: the write is performed, the read is ignored, no rvld is produced for it.
- Illegal func3 (011, 110, 111) is treated as W for reads. For writes it performs no array update, but wack is still pulsed.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0. Handling is defined under Optional Feature.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - dmem_err port exists.
  - Misaligned or illegal-func3 writes: no array update; dmem_wack=1 and dmem_err=1 in cycle N+1.
  - Misaligned or illegal-func3 reads: dmem_rvld=1 with dmem_rdata=0 and dmem_err=1 in cycle N+RD_LAT.
  - dmem_err is 0 in all other cycles.
- Undefined:
  - No dmem_err port.
  - Misaligned accesses are force-aligned: H clears addr[0], W clears addr[1:0], and the access proceeds normally.
  - Illegal func3 handled as in Behaviour.

Test Plan:
- SW 0xDEADBEEF at 0x100, then LW 0x100 -> wack one cycle after SW; rvld exactly RD_LAT cycles after the LW strobe, rdata=0xDEADBEEF.
- After the above: SB 0x7F at 0x103; LB 0x103 -> 0x0000007F. SB 0x80 at 0x102; LB 0x102 -> 0xFFFFFF80; LBU 0x102 -> 0x00000080.
- SH 0x8001 at 0x106; LH 0x106 -> 0xFFFF8001; LHU 0x106 -> 0x00008001; LW 0x104 -> 0x8001xxxx with low half unchanged.
- Four consecutive-cycle LW strobes to 0x0, 0x4, 0x8, 0xC (preloaded 1, 2, 3, 4) -> rvld on four consecutive cycles with data 1, 2, 3, 4 in order.
- Issue LW, assert rstn=0 one cycle later, release -> no rvld ever appears for that LW; all outputs 0 during reset.
- LW at 0x102: with DMEM_ERR_EN -> rvld, rdata=0, err=1. Without DMEM_ERR_EN -> returns the word at 0x100.
